// File: rtl/ntt_pkg.sv
// Shared constants and types for the NTT pointwise-multiply controller.
// Holds the FSM encoding, default geometry and the coefficient modulus.
package ntt_pkg;

  localparam int N_DEF  = 19;
  localparam int D_DEF  = 8;
  localparam int AW_DEF = 5;

  // Coefficient modulus 7*2^16+1; it fits in N_DEF bits.
  localparam int unsigned Q_MOD = 32'd458753;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/point_mult_ctrl_if.sv
// Bundle between the pointwise-multiply sequencer, the NTT control FSM and the
// coefficient RAM banks; master is the sequencer, slave is the surrounding system.
interface point_mult_ctrl_if
  import ntt_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int D  = D_DEF,
  parameter int AW = AW_DEF
) ();

  logic           start;
  logic [AW:0]    cfg_len;
  logic           busy;
  logic           done;
  logic           rd_en;
  logic [AW-1:0]  rd_addr;
  logic [D*N-1:0] a_rdata;
  logic [D*N-1:0] b_rdata;
  logic           wr_en;
  logic [AW-1:0]  wr_addr;
  logic [D*N-1:0] wr_data;

  modport master (
    input  start, cfg_len, a_rdata, b_rdata,
    output busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );

  modport slave (
    output start, cfg_len, a_rdata, b_rdata,
    input  busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/point_mod_mult.sv
// D-lane pointwise modular multiplier: lane i of p = (a lane i * b lane i) mod Q_MOD.
// Purely combinational; lanes are independent with no cross-lane carry.
module point_mod_mult
  import ntt_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int D = D_DEF
) (
  input  logic [D*N-1:0] a,
  input  logic [D*N-1:0] b,
  output logic [D*N-1:0] p
);

  localparam logic [2*N-1:0] QW = (2*N)'(Q_MOD);

  for (genvar i = 0; i < D; i++) begin : g_lane
    logic [2*N-1:0] prod;

    assign prod = (2*N)'(a[i*N +: N]) * (2*N)'(b[i*N +: N]);
    // Remainder is below Q_MOD < 2^N, so the truncation loses nothing.
    assign p[i*N +: N] = N'(prod % QW);
  end

endmodule

// File: rtl/point_mult_ctrl.sv
// Sequencer streaming cfg_len packed words from the a/b memories through
// point_mod_mult into the result memory: sync-read stage, then registered product.
module point_mult_ctrl
  import ntt_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int D  = D_DEF,
  parameter int AW = AW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  point_mult_ctrl_if.master bus
);

  state_e         state;
  state_e         state_nxt;
  // One bit wider than the address so a full 2^AW transfer never wraps.
  logic [AW:0]    rd_cnt;
  logic [AW:0]    len_q;
  logic           rd_en;
  logic [AW-1:0]  rd_addr;
  logic           v1;
  logic           v2;
  logic [AW-1:0]  addr1;
  logic [AW-1:0]  wr_addr_q;
  logic [D*N-1:0] wr_data_q;
  logic [D*N-1:0] product;

  point_mod_mult #(
    .N (N),
    .D (D)
  ) u_mult (
    .a (bus.a_rdata),
    .b (bus.b_rdata),
    .p (product)
  );

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = (bus.cfg_len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        rd_en = 1'b1;
        if (rd_cnt == len_q - (AW+1)'(1)) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        // Last product is being written when stage 1 has emptied.
        if (!v1) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign rd_addr = rd_en ? rd_cnt[AW-1:0] : '0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      rd_cnt    <= '0;
      len_q     <= '0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      addr1     <= '0;
      wr_addr_q <= '0;
      // NOTE: the product register is reset too, because wr_data must read 0 out of reset.
      wr_data_q <= '0;
    end else begin
      state <= state_nxt;

      if (state == IDLE && bus.start) begin
        len_q  <= bus.cfg_len;
        rd_cnt <= '0;
      end else if (rd_en) begin
        rd_cnt <= rd_cnt + (AW+1)'(1);
      end

      v1    <= rd_en;
      addr1 <= rd_addr;
      v2    <= v1;
      if (v1) begin
        wr_data_q <= product;
        wr_addr_q <= addr1;
      end
    end
  end

  assign bus.rd_en   = rd_en;
  assign bus.rd_addr = rd_addr;
  assign bus.busy    = (state == RUN) || (state == DRAIN);
  assign bus.done    = (state == DONE);
  assign bus.wr_en   = v2;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;

endmodule

// File: tb/tb_point_mult_ctrl.sv
// Self-checking bench for point_mult_ctrl: a/b memory models, a write scoreboard
// fed with expected products, and per-scenario timing checks on cycle bitmasks.
module tb_point_mult_ctrl;
  import ntt_pkg::*;

  localparam int N     = N_DEF;
  localparam int D     = D_DEF;
  localparam int AW    = AW_DEF;
  localparam int DEPTH = 1 << AW;

  typedef logic [D*N-1:0] word_t;
  typedef struct {
    logic [AW-1:0] addr;
    word_t         data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  point_mult_ctrl_if #(.N(N), .D(D), .AW(AW)) bus ();

  point_mult_ctrl #(.N(N), .D(D), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  word_t a_mem [DEPTH];
  word_t b_mem [DEPTH];

  // Synchronous-read memories: data valid the cycle after rd_en.
  always @(posedge clk) begin
    if (bus.rd_en) begin
      bus.a_rdata <= a_mem[bus.rd_addr];
      bus.b_rdata <= b_mem[bus.rd_addr];
    end
  end

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  logic [63:0]   rd_m, wr_m, busy_m, done_m;
  logic [AW-1:0] rd_addr_log [64];

  // Scoreboard: every write is popped against the oldest expected entry.
  always @(negedge clk) begin
    if (bus.wr_en) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_write: got write addr=%0d, required no write", bus.wr_addr);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (bus.wr_addr !== e.addr || bus.wr_data !== e.data) begin
          n_fail++;
          $display("FAIL sb_write: got addr=%0d data=%h, required addr=%0d data=%h",
                   bus.wr_addr, bus.wr_data, e.addr, e.data);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] rng(input int lo, input int hi);
    logic [63:0] r;
    r = '0;
    for (int i = lo; i <= hi; i++) r[i] = 1'b1;
    return r;
  endfunction

  function automatic word_t fill_lanes(input int v);
    word_t w;
    for (int i = 0; i < D; i++) w[i*N +: N] = N'(v);
    return w;
  endfunction

  function automatic word_t ramp(input int base);
    word_t w;
    for (int i = 0; i < D; i++) w[i*N +: N] = N'(base + i);
    return w;
  endfunction

  function automatic word_t rand_word(input int bits);
    word_t w;
    for (int i = 0; i < D; i++) w[i*N +: N] = N'($urandom_range((1 << bits) - 1, 0));
    return w;
  endfunction

  // Reference modular multiply, lane by lane.
  function automatic word_t model_mult(input word_t a, input word_t b);
    word_t           r;
    longint unsigned p;
    for (int i = 0; i < D; i++) begin
      p = longint'(a[i*N +: N]) * longint'(b[i*N +: N]);
      r[i*N +: N] = N'(p % longint'(Q_MOD));
    end
    return r;
  endfunction

  task automatic push_exp(input int addr, input word_t data);
    exp_t e;
    e.addr = AW'(addr);
    e.data = data;
    sb.push_back(e);
  endtask

  // Drive start for one cycle; returns just after the accepting edge (cycle 0).
  task automatic launch(input int len);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.cfg_len = (AW+1)'(len);
    @(posedge clk);
  endtask

  // Record output activity for cycles 1..ncyc; optionally pulse start mid-run.
  task automatic observe(input int ncyc, input logic [63:0] start_m, input int next_len);
    rd_m = '0; wr_m = '0; busy_m = '0; done_m = '0;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      rd_m[c]        = bus.rd_en;
      wr_m[c]        = bus.wr_en;
      busy_m[c]      = bus.busy;
      done_m[c]      = bus.done;
      rd_addr_log[c] = bus.rd_addr;
      bus.start      = start_m[c];
      if (start_m[c]) bus.cfg_len = (AW+1)'(next_len);
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    logic [3+2*AW+D*N-1:0] outs;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    outs = {bus.busy, bus.done, bus.rd_en, bus.wr_en, bus.rd_addr, bus.wr_addr, bus.wr_data};
    n_checks++;
    if (outs !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h, required 0", outs); end
    rst_n = 1'b1;

    for (int k = 0; k < DEPTH; k++) begin
      a_mem[k] = fill_lanes(1);
      b_mem[k] = rand_word(17);
    end
    push_exp(0, b_mem[0]);
    push_exp(1, b_mem[1]);
    launch(8);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (c == 4) rst_n = 1'b0;
    end
    @(negedge clk);
    outs = {bus.busy, bus.done, bus.rd_en, bus.wr_en, bus.rd_addr, bus.wr_addr, bus.wr_data};
    n_checks++;
    if (outs !== '0) begin n_fail++; $display("FAIL midjob_reset_outputs: got %h, required 0", outs); end
    rst_n = 1'b1;

    observe(6, '0, 0);
    n_checks++;
    if ((rd_m | wr_m | busy_m | done_m) !== '0) begin
      n_fail++;
      $display("FAIL midjob_reset_quiet: got rd=%h wr=%h busy=%h done=%h, required all 0",
               rd_m, wr_m, busy_m, done_m);
    end

    push_exp(0, b_mem[0]);
    push_exp(1, b_mem[1]);
    launch(2);
    observe(7, '0, 0);
    n_checks++;
    if (done_m !== rng(5, 5)) begin n_fail++; $display("FAIL restart_done: got %h, required %h", done_m, rng(5, 5)); end
    n_checks++;
    if (wr_m !== rng(3, 4)) begin n_fail++; $display("FAIL restart_wr: got %h, required %h", wr_m, rng(3, 4)); end
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL restart_sb_empty: got %0d left, required 0", sb.size()); end
  endtask

  task automatic test_zero_operands();
    for (int k = 0; k < DEPTH; k++) begin
      a_mem[k] = '0;
      b_mem[k] = rand_word(N);
    end
    for (int k = 0; k < 4; k++) push_exp(k, '0);
    launch(4);
    observe(9, '0, 0);
    n_checks++;
    if (rd_m !== rng(1, 4)) begin n_fail++; $display("FAIL zero_ops_rd: got %h, required %h", rd_m, rng(1, 4)); end
    n_checks++;
    if (wr_m !== rng(3, 6)) begin n_fail++; $display("FAIL zero_ops_wr: got %h, required %h", wr_m, rng(3, 6)); end
    n_checks++;
    if (busy_m !== rng(1, 6)) begin n_fail++; $display("FAIL zero_ops_busy: got %h, required %h", busy_m, rng(1, 6)); end
    n_checks++;
    if (done_m !== rng(7, 7)) begin n_fail++; $display("FAIL zero_ops_done: got %h, required %h", done_m, rng(7, 7)); end
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL zero_ops_sb_empty: got %0d left, required 0", sb.size()); end
  endtask

  task automatic test_identity_full();
    for (int k = 0; k < DEPTH; k++) begin
      a_mem[k] = fill_lanes(1);
      b_mem[k] = ramp(k * 8);
      push_exp(k, ramp(k * 8));
    end
    launch(32);
    observe(37, '0, 0);
    for (int c = 1; c <= 32; c++) begin
      n_checks++;
      if (rd_addr_log[c] !== AW'(c - 1)) begin
        n_fail++;
        $display("FAIL identity_rd_addr: got %0d at cycle %0d, required %0d", rd_addr_log[c], c, c - 1);
      end
    end
    n_checks++;
    if (wr_m !== rng(3, 34)) begin n_fail++; $display("FAIL identity_wr: got %h, required %h", wr_m, rng(3, 34)); end
    n_checks++;
    if (done_m !== rng(35, 35)) begin n_fail++; $display("FAIL identity_done: got %h, required %h", done_m, rng(35, 35)); end
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL identity_sb_empty: got %0d left, required 0", sb.size()); end
  endtask

  task automatic test_random_products();
    for (int k = 0; k < DEPTH; k++) begin
      a_mem[k] = rand_word(N);
      b_mem[k] = rand_word(N);
    end
    for (int k = 0; k < 5; k++) push_exp(k, model_mult(a_mem[k], b_mem[k]));
    launch(5);
    observe(9, '0, 0);
    n_checks++;
    if (done_m !== rng(8, 8)) begin n_fail++; $display("FAIL random_done: got %h, required %h", done_m, rng(8, 8)); end
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL random_sb_empty: got %0d left, required 0", sb.size()); end
  endtask

  task automatic test_zero_length();
    launch(0);
    observe(4, '0, 0);
    n_checks++;
    if (done_m !== rng(1, 1)) begin n_fail++; $display("FAIL zero_len_done: got %h, required %h", done_m, rng(1, 1)); end
    n_checks++;
    if ((rd_m | wr_m | busy_m) !== '0) begin
      n_fail++;
      $display("FAIL zero_len_quiet: got rd=%h wr=%h busy=%h, required all 0", rd_m, wr_m, busy_m);
    end
  endtask

  task automatic test_start_while_busy();
    for (int k = 0; k < DEPTH; k++) begin
      a_mem[k] = fill_lanes(1);
      b_mem[k] = rand_word(17);
    end
    for (int k = 0; k < 6; k++) push_exp(k, b_mem[k]);
    launch(6);
    observe(12, rng(2, 2) | rng(5, 5), 3);
    n_checks++;
    if (rd_m !== rng(1, 6)) begin n_fail++; $display("FAIL busy_start_rd: got %h, required %h", rd_m, rng(1, 6)); end
    n_checks++;
    if (wr_m !== rng(3, 8)) begin n_fail++; $display("FAIL busy_start_wr: got %h, required %h", wr_m, rng(3, 8)); end
    n_checks++;
    if (done_m !== rng(9, 9)) begin n_fail++; $display("FAIL busy_start_done: got %h, required %h", done_m, rng(9, 9)); end
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL busy_start_sb_empty: got %0d left, required 0", sb.size()); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp_rd, exp_wr, exp_done;
    for (int k = 0; k < DEPTH; k++) begin
      a_mem[k] = fill_lanes(1);
      b_mem[k] = rand_word(17);
    end
    push_exp(0, b_mem[0]);
    push_exp(0, b_mem[0]);
    push_exp(1, b_mem[1]);
    launch(1);
    // Second start lands in cycle 5, the first cycle back in IDLE after done at 4.
    observe(12, rng(5, 5), 2);
    exp_rd   = rng(1, 1) | rng(6, 7);
    exp_wr   = rng(3, 3) | rng(8, 9);
    exp_done = rng(4, 4) | rng(10, 10);
    n_checks++;
    if (rd_m !== exp_rd) begin n_fail++; $display("FAIL b2b_rd: got %h, required %h", rd_m, exp_rd); end
    n_checks++;
    if (wr_m !== exp_wr) begin n_fail++; $display("FAIL b2b_wr: got %h, required %h", wr_m, exp_wr); end
    n_checks++;
    if (done_m !== exp_done) begin n_fail++; $display("FAIL b2b_done: got %h, required %h", done_m, exp_done); end
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL b2b_sb_empty: got %0d left, required 0", sb.size()); end
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.cfg_len = '0;
    test_reset();
    test_zero_operands();
    test_identity_full();
    test_random_products();
    test_zero_length();
    test_start_while_busy();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
